// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two request ports (A, B) sharing one single-port SRAM.
// One access in flight at a time: IDLE (arbitrate) -> ISSUE (drive SRAM) -> RESP (ready pulse).
module sram_port_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        a_valid,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [3:0]  a_wstrb,
    output logic        a_ready,
    output logic [31:0] a_rdata,

    input  logic        b_valid,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  b_wstrb,
    output logic        b_ready,
    output logic [31:0] b_rdata,

    output logic        sram_csb0,
    output logic        sram_web0,
    output logic [3:0]  sram_wmask0,
    output logic [8:0]  sram_addr0,
    output logic [31:0] sram_din0,
    input  logic [31:0] sram_dout0
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        last_a_q, last_a_d;      // 1 = port A was granted last
    logic        gnt_a_q, gnt_a_d;        // port owning the access in flight
    logic        rd_hit_q, rd_hit_d;      // in-range read: return sram_dout0 in RESP
    logic        a_ready_q, a_ready_d;
    logic        b_ready_q, b_ready_d;
    logic        sram_csb0_q, sram_csb0_d;
    logic        sram_web0_q, sram_web0_d;
    logic [3:0]  sram_wmask0_q, sram_wmask0_d;
    logic [8:0]  sram_addr0_q, sram_addr0_d;
    logic [31:0] sram_din0_q, sram_din0_d;

    logic        sel_a;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic [31:0] offset;
    logic        in_range;

    // Arbitration and address decode for the request being granted in IDLE
    always_comb begin
        if (a_valid && b_valid) begin
            sel_a = (FIXED_PRIO != 0) ? 1'b1 : !last_a_q;
        end else begin
            sel_a = a_valid;
        end
        sel_addr  = sel_a ? a_addr  : b_addr;
        sel_wdata = sel_a ? a_wdata : b_wdata;
        sel_wstrb = sel_a ? a_wstrb : b_wstrb;
        offset    = sel_addr - BASE_ADDR;
        in_range  = (offset < 32'd2048);
    end

    // Next-state logic; the granted request is captured directly into the
    // SRAM drive registers so they present it throughout ISSUE
    always_comb begin
        state_d       = state_q;
        last_a_d      = last_a_q;
        gnt_a_d       = gnt_a_q;
        rd_hit_d      = rd_hit_q;
        a_ready_d     = 1'b0;
        b_ready_d     = 1'b0;
        sram_csb0_d   = 1'b1;
        sram_web0_d   = 1'b1;
        sram_wmask0_d = '0;
        sram_addr0_d  = '0;
        sram_din0_d   = '0;
        case (state_q)
            IDLE: begin
                if (a_valid || b_valid) begin
                    gnt_a_d  = sel_a;
                    rd_hit_d = in_range && (sel_wstrb == 4'h0);
                    if (in_range) begin
                        sram_csb0_d   = 1'b0;
                        sram_web0_d   = (sel_wstrb == 4'h0);
                        sram_wmask0_d = sel_wstrb;
                        sram_addr0_d  = offset[10:2];
                        sram_din0_d   = sel_wdata;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                a_ready_d = gnt_a_q;
                b_ready_d = !gnt_a_q;
                state_d   = RESP;
            end
            RESP: begin
                last_a_d = gnt_a_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_a_q      <= 1'b0;
            gnt_a_q       <= 1'b0;
            rd_hit_q      <= 1'b0;
            a_ready_q     <= 1'b0;
            b_ready_q     <= 1'b0;
            sram_csb0_q   <= 1'b1;
            sram_web0_q   <= 1'b1;
            sram_wmask0_q <= '0;
            sram_addr0_q  <= '0;
            sram_din0_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_a_q      <= last_a_d;
            gnt_a_q       <= gnt_a_d;
            rd_hit_q      <= rd_hit_d;
            a_ready_q     <= a_ready_d;
            b_ready_q     <= b_ready_d;
            sram_csb0_q   <= sram_csb0_d;
            sram_web0_q   <= sram_web0_d;
            sram_wmask0_q <= sram_wmask0_d;
            sram_addr0_q  <= sram_addr0_d;
            sram_din0_q   <= sram_din0_d;
        end
    end

    // SRAM read data is only valid during RESP, so rdata is steered
    // combinationally from sram_dout0 rather than registered
    always_comb begin
        a_rdata = (a_ready_q && rd_hit_q) ? sram_dout0 : '0;
        b_rdata = (b_ready_q && rd_hit_q) ? sram_dout0 : '0;
    end

    assign a_ready     = a_ready_q;
    assign b_ready     = b_ready_q;
    assign sram_csb0   = sram_csb0_q;
    assign sram_web0   = sram_web0_q;
    assign sram_wmask0 = sram_wmask0_q;
    assign sram_addr0  = sram_addr0_q;
    assign sram_din0   = sram_din0_q;

endmodule
